// File: rtl/dlo_phase_arbiter.sv
// Round-robin owner of a shared domino DLO datapath: per transaction it precharges,
// releases the stage enables one domino stage at a time, then strobes the result capture.
module dlo_phase_arbiter #(
    parameter int NSTG     = 2,
    parameter int PRE_CYC  = 1,
    parameter int EVAL_CYC = 1
) (
    input  logic            CP,
    input  logic            RST,
    input  logic [1:0]      REQ,
    output logic [1:0]      GNT,
    output logic [1:0]      ACK,
    output logic [NSTG-1:0] DLO_CP,
    output logic            CAP,
    output logic            BUSY
);

    localparam int PMAX = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int SW   = $clog2(NSTG + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_CYC - 1);
    localparam logic [PW-1:0] EVAL_LAST = PW'(EVAL_CYC - 1);
    localparam logic [SW-1:0] STG_LAST  = SW'(NSTG - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_EVAL, S_CAP} state_t;

    state_t        r_state;
    logic [PW-1:0] r_cnt;
    logic [SW-1:0] r_stg;
    logic          r_last;

    logic [1:0]    w_gnt_idle;
    logic [1:0]    w_req_next;
    logic [1:0]    w_gnt_next;

    // Tie goes to whichever requester was not served last.
    function automatic logic [1:0] f_arb(input logic [1:0] req, input logic last);
        if (req == 2'b11) return last ? 2'b01 : 2'b10;
        return req;
    endfunction

    // Domino order: every stage up to and including k is evaluating.
    function automatic logic [NSTG-1:0] f_stg_mask(input logic [SW-1:0] k);
        logic [NSTG-1:0] m;
        for (int i = 0; i < NSTG; i++) m[i] = (SW'(i) <= k);
        return m;
    endfunction

    assign w_gnt_idle = f_arb(REQ, r_last);
    assign w_req_next = REQ & ~GNT;
    assign w_gnt_next = f_arb(w_req_next, r_last);

    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_stg   <= '0;
            r_last  <= 1'b1;
            GNT     <= '0;
            ACK     <= '0;
            DLO_CP  <= '0;
            CAP     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            ACK <= '0;
            CAP <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|REQ) begin
                        r_state <= S_PRE;
                        r_cnt   <= '0;
                        GNT     <= w_gnt_idle;
                        BUSY    <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (r_cnt == PRE_LAST) begin
                        r_state <= S_EVAL;
                        r_cnt   <= '0;
                        r_stg   <= '0;
                        DLO_CP  <= f_stg_mask('0);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (r_cnt == EVAL_LAST) begin
                        r_cnt <= '0;
                        if (r_stg == STG_LAST) begin
                            r_state <= S_CAP;
                            DLO_CP  <= '1;
                            CAP     <= 1'b1;
                            ACK     <= GNT;
                            r_last  <= GNT[1];
                        end else begin
                            r_stg  <= r_stg + 1'b1;
                            DLO_CP <= f_stg_mask(r_stg + 1'b1);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CAP: begin
                    // The owner's own request is ignored here so the other side gets its turn.
                    DLO_CP <= '0;
                    r_cnt  <= '0;
                    r_stg  <= '0;
                    if (|w_req_next) begin
                        r_state <= S_PRE;
                        GNT     <= w_gnt_next;
                    end else begin
                        r_state <= S_IDLE;
                        GNT     <= '0;
                        BUSY    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
